// File: rtl/writeback_stage_if.sv
// Shared types and the bus bundle between the writeback stage and its surroundings.
// WB_PERF_CNT_EN adds the retire/mispredict counter outputs to the bundle.
package writeback_stage_pkg;
  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;

  typedef enum logic [1:0] {
    INST_ALU    = 2'd0,
    INST_BRANCH = 2'd1,
    INST_LOAD   = 2'd2,
    INST_RSVD   = 2'd3
  } e_inst_type;

  // Contents of the writeback stage register
  typedef struct packed {
    logic              v;
    logic [XLEN-1:0]   pc;
    e_inst_type        itype;
    logic              cmp;
    logic [XLEN-1:0]   alu;
    logic              link;
    logic [XLEN-1:0]   pred;
    logic [REG_AW-1:0] rd;
  } stage_t;
endpackage

interface writeback_stage_if;
  import writeback_stage_pkg::*;

  logic              ex_valid;
  logic [XLEN-1:0]   ex_pc;
  e_inst_type        ex_inst_type;
  logic              ex_cmp_out;
  logic [XLEN-1:0]   ex_alu_out;
  logic              ex_is_linking_branch;
  logic [XLEN-1:0]   ex_pred_next_pc;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_stall;

  logic              rf_we;
  logic [REG_AW-1:0] rf_waddr;
  logic [XLEN-1:0]   rf_wdata;

  logic              redirect;
  logic [XLEN-1:0]   redirect_pc;

  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [XLEN-1:0]   mem_req_addr;
  logic              mem_rsp_valid;
  logic [XLEN-1:0]   mem_rsp_data;

`ifdef WB_PERF_CNT_EN
  logic [31:0]       retire_count;
  logic [31:0]       mispredict_count;
`endif

  // Environment side: Execute, Fetch, register file and memory controller
  modport master (
    output ex_valid, ex_pc, ex_inst_type, ex_cmp_out, ex_alu_out,
           ex_is_linking_branch, ex_pred_next_pc, ex_rd,
           mem_req_ready, mem_rsp_valid, mem_rsp_data,
    input  ex_stall, rf_we, rf_waddr, rf_wdata, redirect, redirect_pc,
           mem_req_valid, mem_req_addr
`ifdef WB_PERF_CNT_EN
    , input retire_count, mispredict_count
`endif
  );

  // Writeback stage side
  modport slave (
    input  ex_valid, ex_pc, ex_inst_type, ex_cmp_out, ex_alu_out,
           ex_is_linking_branch, ex_pred_next_pc, ex_rd,
           mem_req_ready, mem_rsp_valid, mem_rsp_data,
    output ex_stall, rf_we, rf_waddr, rf_wdata, redirect, redirect_pc,
           mem_req_valid, mem_req_addr
`ifdef WB_PERF_CNT_EN
    , output retire_count, mispredict_count
`endif
  );
endinterface

// File: rtl/writeback_stage.sv
// Final pipeline stage: retires one instruction per cycle, resolves branches, squashes the
// wrong path after a redirect and services loads. WB_PERF_CNT_EN enables perf counters.
module writeback_stage
  import writeback_stage_pkg::*;
#(
  parameter int unsigned FLUSH_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  writeback_stage_if.slave   wb
);

  localparam int unsigned SQ_W = 3;

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_MEM_REQ  = 2'd1,
    S_MEM_WAIT = 2'd2
  } state_e;

  state_e            r_state;
  state_e            w_next_state;
  stage_t            r_stage;
  logic [SQ_W-1:0]   r_sq;
  logic [SQ_W-1:0]   w_sq_next;

  logic              w_kill;
  logic              w_live;
  logic              w_taken;
  logic [XLEN-1:0]   w_pc_plus4;
  logic [XLEN-1:0]   w_actual;
  logic              w_mispred;
  logic              w_cap_load;

  logic              w_stall;
  logic              w_rf_we;
  logic [REG_AW-1:0] w_rf_waddr;
  logic [XLEN-1:0]   w_rf_wdata;
  logic              w_redirect;
  logic [XLEN-1:0]   w_redirect_pc;
  logic              w_mem_req_valid;
  logic [XLEN-1:0]   w_mem_req_addr;

  // Branch resolution for the instruction in the stage
  assign w_kill     = (r_sq != '0);
  assign w_live     = r_stage.v && !w_kill;
  assign w_taken    = r_stage.link | r_stage.cmp;
  assign w_pc_plus4 = r_stage.pc + XLEN'(4);
  assign w_actual   = w_taken ? r_stage.alu : w_pc_plus4;
  assign w_mispred  = (w_actual != r_stage.pred);

  // Squash counter: reload on redirect, count down once per squashed valid instruction
  always_comb begin
    w_sq_next = r_sq;
    if (w_redirect) begin
      w_sq_next = SQ_W'(FLUSH_DEPTH);
    end else if (r_stage.v && w_kill) begin
      w_sq_next = r_sq - SQ_W'(1);
    end
  end

  // An incoming load is live only if the counter it will see is zero
  assign w_cap_load = wb.ex_valid && (wb.ex_inst_type == INST_LOAD) && (w_sq_next == '0);

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_RUN;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_RUN: begin
        if (w_cap_load) w_next_state = S_MEM_REQ;
      end
      S_MEM_REQ: begin
        if (wb.mem_req_ready) w_next_state = S_MEM_WAIT;
      end
      S_MEM_WAIT: begin
        if (wb.mem_rsp_valid) w_next_state = w_cap_load ? S_MEM_REQ : S_RUN;
      end
      default: w_next_state = S_RUN;
    endcase
  end

  // Output logic
  always_comb begin
    w_stall         = 1'b0;
    w_rf_we         = 1'b0;
    w_rf_waddr      = '0;
    w_rf_wdata      = '0;
    w_redirect      = 1'b0;
    w_redirect_pc   = '0;
    w_mem_req_valid = 1'b0;
    w_mem_req_addr  = '0;
    unique case (r_state)
      S_RUN: begin
        if (w_live) begin
          unique case (r_stage.itype)
            INST_ALU: begin
              if (r_stage.rd != '0) begin
                w_rf_we    = 1'b1;
                w_rf_waddr = r_stage.rd;
                w_rf_wdata = r_stage.alu;
              end
            end
            INST_BRANCH: begin
              if (r_stage.link && (r_stage.rd != '0)) begin
                w_rf_we    = 1'b1;
                w_rf_waddr = r_stage.rd;
                w_rf_wdata = w_pc_plus4;
              end
              if (w_mispred) begin
                w_redirect    = 1'b1;
                w_redirect_pc = w_actual;
              end
            end
            default: ;
          endcase
        end
      end
      S_MEM_REQ: begin
        w_stall         = 1'b1;
        w_mem_req_valid = 1'b1;
        w_mem_req_addr  = r_stage.alu;
      end
      S_MEM_WAIT: begin
        w_stall = !wb.mem_rsp_valid;
        if (wb.mem_rsp_valid && (r_stage.rd != '0)) begin
          w_rf_we    = 1'b1;
          w_rf_waddr = r_stage.rd;
          w_rf_wdata = wb.mem_rsp_data;
        end
      end
      default: ;
    endcase
  end

  // Stage register and squash counter
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_stage <= '0;
      r_sq    <= '0;
    end else begin
      if (!w_stall) begin
        r_stage.v     <= wb.ex_valid;
        r_stage.pc    <= wb.ex_pc;
        r_stage.itype <= wb.ex_inst_type;
        r_stage.cmp   <= wb.ex_cmp_out;
        r_stage.alu   <= wb.ex_alu_out;
        r_stage.link  <= wb.ex_is_linking_branch;
        r_stage.pred  <= wb.ex_pred_next_pc;
        r_stage.rd    <= wb.ex_rd;
      end
      r_sq <= w_sq_next;
    end
  end

  assign wb.ex_stall      = w_stall;
  assign wb.rf_we         = w_rf_we;
  assign wb.rf_waddr      = w_rf_waddr;
  assign wb.rf_wdata      = w_rf_wdata;
  assign wb.redirect      = w_redirect;
  assign wb.redirect_pc   = w_redirect_pc;
  assign wb.mem_req_valid = w_mem_req_valid;
  assign wb.mem_req_addr  = w_mem_req_addr;

`ifdef WB_PERF_CNT_EN
  logic [31:0] r_retire_count;
  logic [31:0] r_mispredict_count;
  logic        w_retire;

  // Loads commit on their response edge; everything else on the edge closing its stage cycle
  assign w_retire = ((r_state == S_RUN) && w_live && (r_stage.itype != INST_LOAD)) ||
                    ((r_state == S_MEM_WAIT) && wb.mem_rsp_valid);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_retire_count     <= '0;
      r_mispredict_count <= '0;
    end else begin
      if (w_retire)   r_retire_count     <= r_retire_count + 32'd1;
      if (w_redirect) r_mispredict_count <= r_mispredict_count + 32'd1;
    end
  end

  assign wb.retire_count     = r_retire_count;
  assign wb.mispredict_count = r_mispredict_count;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Directed, table-driven bench for writeback_stage (FLUSH_DEPTH=2) plus load/reset sequences.
module tb_writeback_stage;
  import writeback_stage_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  writeback_stage_if u_if();

  writeback_stage #(.FLUSH_DEPTH(2)) u_dut (
    .clk (clk),
    .rst (rst),
    .wb  (u_if.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [31:0] pc;
    e_inst_type  t;
    logic        cmp;
    logic [31:0] alu;
    logic        link;
    logic [31:0] pred;
    logic [4:0]  rd;
    logic        e_we;
    logic [4:0]  e_waddr;
    logic [31:0] e_wdata;
    logic        e_redir;
    logic [31:0] e_rpc;
  } vec_t;

  function automatic vec_t mk(input logic v, input logic [31:0] pc, input e_inst_type t,
                              input logic cmp, input logic [31:0] alu, input logic link,
                              input logic [31:0] pred, input logic [4:0] rd,
                              input logic e_we, input logic [4:0] e_waddr,
                              input logic [31:0] e_wdata, input logic e_redir,
                              input logic [31:0] e_rpc);
    vec_t r;
    r.v = v; r.pc = pc; r.t = t; r.cmp = cmp; r.alu = alu; r.link = link;
    r.pred = pred; r.rd = rd; r.e_we = e_we; r.e_waddr = e_waddr; r.e_wdata = e_wdata;
    r.e_redir = e_redir; r.e_rpc = e_rpc;
    return r;
  endfunction

  task automatic drive(input vec_t x);
    u_if.ex_valid             = x.v;
    u_if.ex_pc                = x.pc;
    u_if.ex_inst_type         = x.t;
    u_if.ex_cmp_out           = x.cmp;
    u_if.ex_alu_out           = x.alu;
    u_if.ex_is_linking_branch = x.link;
    u_if.ex_pred_next_pc      = x.pred;
    u_if.ex_rd                = x.rd;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, " rf_we"},         32'(u_if.rf_we), 32'd0);
    check({tag, " rf_waddr"},      32'(u_if.rf_waddr), 32'd0);
    check({tag, " rf_wdata"},      u_if.rf_wdata, 32'd0);
    check({tag, " redirect"},      32'(u_if.redirect), 32'd0);
    check({tag, " redirect_pc"},   u_if.redirect_pc, 32'd0);
    check({tag, " ex_stall"},      32'(u_if.ex_stall), 32'd0);
    check({tag, " mem_req_valid"}, 32'(u_if.mem_req_valid), 32'd0);
    check({tag, " mem_req_addr"},  u_if.mem_req_addr, 32'd0);
  endtask

  function automatic vec_t bubble();
    return mk(0, 0, INST_ALU, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  vec_t vecs[$];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs.push_back(mk(1, 32'h0,        INST_ALU,    0, 32'h1234, 0, 32'h0,   5, 1, 5,  32'h1234, 0, 32'h0));
    vecs.push_back(bubble());
    vecs.push_back(mk(1, 32'h0,        INST_ALU,    0, 32'h55,   0, 32'h0,   0, 0, 0,  32'h0,    0, 32'h0));
    vecs.push_back(mk(1, 32'h100,      INST_BRANCH, 0, 32'h200,  0, 32'h104, 0, 0, 0,  32'h0,    0, 32'h0));
    vecs.push_back(mk(1, 32'h100,      INST_BRANCH, 1, 32'h200,  0, 32'h104, 0, 0, 0,  32'h0,    1, 32'h200));
    vecs.push_back(mk(1, 32'h0,        INST_ALU,    0, 32'h11,   0, 32'h0,   3, 0, 0,  32'h0,    0, 32'h0));
    vecs.push_back(bubble());
    vecs.push_back(mk(1, 32'h0,        INST_ALU,    0, 32'h22,   0, 32'h0,   4, 0, 0,  32'h0,    0, 32'h0));
    vecs.push_back(mk(1, 32'h0,        INST_ALU,    0, 32'h33,   0, 32'h0,   6, 1, 6,  32'h33,   0, 32'h0));
    vecs.push_back(mk(1, 32'h40,       INST_BRANCH, 0, 32'h80,   1, 32'h80,  1, 1, 1,  32'h44,   0, 32'h0));
    vecs.push_back(mk(1, 32'hFFFFFFFC, INST_BRANCH, 0, 32'h300,  1, 32'h0,   2, 1, 2,  32'h0,    1, 32'h300));
    vecs.push_back(mk(1, 32'h0,        INST_LOAD,   0, 32'h5000, 0, 32'h0,   7, 0, 0,  32'h0,    0, 32'h0));
    vecs.push_back(mk(1, 32'h0,        INST_BRANCH, 1, 32'h999,  0, 32'h4,   0, 0, 0,  32'h0,    0, 32'h0));
    vecs.push_back(mk(1, 32'h0,        INST_ALU,    0, 32'h77,   0, 32'h0,   8, 1, 8,  32'h77,   0, 32'h0));
    vecs.push_back(mk(1, 32'h0,        INST_RSVD,   0, 32'h5,    0, 32'h0,   9, 0, 0,  32'h0,    0, 32'h0));
    vecs.push_back(mk(1, 32'h200,      INST_BRANCH, 0, 32'h900,  0, 32'h300, 0, 0, 0,  32'h0,    1, 32'h204));
    vecs.push_back(mk(1, 32'h0,        INST_ALU,    0, 32'hA,    0, 32'h0,  10, 0, 0,  32'h0,    0, 32'h0));
    vecs.push_back(mk(1, 32'h0,        INST_ALU,    0, 32'hB,    0, 32'h0,  11, 0, 0,  32'h0,    0, 32'h0));
    vecs.push_back(mk(1, 32'h0,        INST_ALU,    0, 32'hFFFFFFFF, 0, 32'h0, 31, 1, 31, 32'hFFFFFFFF, 0, 32'h0));

    drive(bubble());
    u_if.mem_req_ready = 1'b0;
    u_if.mem_rsp_valid = 1'b0;
    u_if.mem_rsp_data  = '0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 check_idle("reset");
    @(negedge clk) rst = 1'b1;

    // Single-cycle retire table
    foreach (vecs[i]) begin
      @(negedge clk) drive(vecs[i]);
      @(posedge clk); #1;
      check($sformatf("v%0d rf_we", i), 32'(u_if.rf_we), 32'(vecs[i].e_we));
      if (vecs[i].e_we) begin
        check($sformatf("v%0d rf_waddr", i), 32'(u_if.rf_waddr), 32'(vecs[i].e_waddr));
        check($sformatf("v%0d rf_wdata", i), u_if.rf_wdata, vecs[i].e_wdata);
      end
      check($sformatf("v%0d redirect", i), 32'(u_if.redirect), 32'(vecs[i].e_redir));
      if (vecs[i].e_redir)
        check($sformatf("v%0d redirect_pc", i), u_if.redirect_pc, vecs[i].e_rpc);
      check($sformatf("v%0d ex_stall", i), 32'(u_if.ex_stall), 32'd0);
      check($sformatf("v%0d mem_req_valid", i), 32'(u_if.mem_req_valid), 32'd0);
    end

    // Load with slow acceptance, response two cycles after accept, then a held ALU retires
    @(negedge clk) drive(mk(1, 32'h0, INST_LOAD, 0, 32'h1000, 0, 32'h0, 12, 0, 0, 0, 0, 0));
    @(posedge clk);
    @(negedge clk) drive(mk(1, 32'h0, INST_ALU, 0, 32'hAA, 0, 32'h0, 13, 0, 0, 0, 0, 0));
    for (int c = 0; c < 3; c++) begin
      check($sformatf("ld1 c%0d req_valid", c), 32'(u_if.mem_req_valid), 32'd1);
      check($sformatf("ld1 c%0d req_addr", c), u_if.mem_req_addr, 32'h1000);
      check($sformatf("ld1 c%0d ex_stall", c), 32'(u_if.ex_stall), 32'd1);
      check($sformatf("ld1 c%0d rf_we", c), 32'(u_if.rf_we), 32'd0);
      @(negedge clk);
    end
    u_if.mem_req_ready = 1'b1;
    check("ld1 accept req_addr", u_if.mem_req_addr, 32'h1000);
    @(negedge clk) u_if.mem_req_ready = 1'b0;
    check("ld1 wait req_valid", 32'(u_if.mem_req_valid), 32'd0);
    check("ld1 wait ex_stall", 32'(u_if.ex_stall), 32'd1);
    @(negedge clk);
    u_if.mem_rsp_valid = 1'b1;
    u_if.mem_rsp_data  = 32'hDEADBEEF;
    #1;
    check("ld1 rsp rf_we", 32'(u_if.rf_we), 32'd1);
    check("ld1 rsp rf_waddr", 32'(u_if.rf_waddr), 32'd12);
    check("ld1 rsp rf_wdata", u_if.rf_wdata, 32'hDEADBEEF);
    check("ld1 rsp ex_stall", 32'(u_if.ex_stall), 32'd0);
    @(posedge clk); #1;
    u_if.mem_rsp_valid = 1'b0;
    drive(bubble());
    #1;
    check("ld1 next rf_we", 32'(u_if.rf_we), 32'd1);
    check("ld1 next rf_waddr", 32'(u_if.rf_waddr), 32'd13);
    check("ld1 next rf_wdata", u_if.rf_wdata, 32'hAA);
    check("ld1 next ex_stall", 32'(u_if.ex_stall), 32'd0);

    // Back-to-back loads: second request the cycle after the first response
    @(negedge clk) drive(mk(1, 32'h0, INST_LOAD, 0, 32'h2000, 0, 32'h0, 14, 0, 0, 0, 0, 0));
    @(posedge clk);
    @(negedge clk);
    drive(mk(1, 32'h0, INST_LOAD, 0, 32'h3000, 0, 32'h0, 15, 0, 0, 0, 0, 0));
    u_if.mem_req_ready = 1'b1;
    check("b2b ld1 req_addr", u_if.mem_req_addr, 32'h2000);
    @(negedge clk);
    u_if.mem_req_ready = 1'b0;
    u_if.mem_rsp_valid = 1'b1;
    u_if.mem_rsp_data  = 32'h11111111;
    #1;
    check("b2b ld1 rf_waddr", 32'(u_if.rf_waddr), 32'd14);
    check("b2b ld1 rf_wdata", u_if.rf_wdata, 32'h11111111);
    @(posedge clk); #1;
    u_if.mem_rsp_valid = 1'b0;
    drive(bubble());
    #1;
    check("b2b ld2 req_valid", 32'(u_if.mem_req_valid), 32'd1);
    check("b2b ld2 req_addr", u_if.mem_req_addr, 32'h3000);
    check("b2b ld2 ex_stall", 32'(u_if.ex_stall), 32'd1);
    check("b2b ld2 rf_we", 32'(u_if.rf_we), 32'd0);
    @(negedge clk) u_if.mem_req_ready = 1'b1;
    @(negedge clk);
    u_if.mem_req_ready = 1'b0;
    u_if.mem_rsp_valid = 1'b1;
    u_if.mem_rsp_data  = 32'h22222222;
    #1;
    check("b2b ld2 rf_waddr", 32'(u_if.rf_waddr), 32'd15);
    check("b2b ld2 rf_wdata", u_if.rf_wdata, 32'h22222222);
    @(posedge clk); #1;
    u_if.mem_rsp_valid = 1'b0;
    #1;
    check("b2b after rf_we", 32'(u_if.rf_we), 32'd0);
    check("b2b after req_valid", 32'(u_if.mem_req_valid), 32'd0);
    check("b2b after ex_stall", 32'(u_if.ex_stall), 32'd0);

    // Reset while waiting for a load response; the late response must be dropped
    @(negedge clk) drive(mk(1, 32'h0, INST_LOAD, 0, 32'h4000, 0, 32'h0, 16, 0, 0, 0, 0, 0));
    @(negedge clk);
    drive(bubble());
    u_if.mem_req_ready = 1'b1;
    @(negedge clk);
    u_if.mem_req_ready = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    u_if.mem_rsp_valid = 1'b1;
    u_if.mem_rsp_data  = 32'h00000BAD;
    #1 check_idle("rst_mid_load");
    @(negedge clk) u_if.mem_rsp_valid = 1'b0;
    check_idle("rst_mid_load after");

    // Reset clears a pending squash
    @(negedge clk) drive(mk(1, 32'h500, INST_BRANCH, 1, 32'h600, 0, 32'h504, 0, 0, 0, 0, 0, 0));
    @(posedge clk); #1;
    check("rst_sq redirect", 32'(u_if.redirect), 32'd1);
    check("rst_sq redirect_pc", u_if.redirect_pc, 32'h600);
    @(negedge clk) begin drive(bubble()); rst = 1'b0; end
    @(negedge clk) begin rst = 1'b1; drive(mk(1, 32'h0, INST_ALU, 0, 32'h77, 0, 32'h0, 17, 0, 0, 0, 0, 0)); end
    @(posedge clk); #1;
    check("rst_sq rf_we", 32'(u_if.rf_we), 32'd1);
    check("rst_sq rf_wdata", u_if.rf_wdata, 32'h77);
    @(negedge clk) drive(bubble());

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/writeback_stage.md
# writeback_stage

Final pipeline stage of the RISC-V core. Registers the Execute stage's results and retires one instruction per cycle: it writes the register file, resolves branches against the predicted next PC, and redirects Fetch on a mispredict. After a redirect it squashes the wrong-path instructions still in flight. Loads are serviced through a valid/ready request to the memory controller plus a response strobe; Execute is stalled while a load is outstanding.

## Interface
- FLUSH_DEPTH, 2: number of younger valid instructions squashed after a redirect (1..7).
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-low.
- ex_valid  in  1  Execute presents a valid instruction.
- ex_pc  in  32  PC of the instruction.
- ex_inst_type  in  e_inst_type  instruction class: INST_ALU, INST_BRANCH or INST_LOAD; any other value retires with no effect.
- ex_cmp_out  in  1  branch condition result.
- ex_alu_out  in  32  ALU result; also the branch target and the load address.
- ex_is_linking_branch  in  1  JAL/JALR: branch always taken, rd <= pc+4.
- ex_pred_next_pc  in  32  next PC predicted by Fetch.
- ex_rd  in  5  destination register.
- ex_stall  out  1  Execute must hold its outputs.
- rf_we  out  1  register file write enable.
- rf_waddr  out  5  register file write address.
- rf_wdata  out  32  register file write data.
- redirect  out  1  one-cycle pulse on a mispredict.
- redirect_pc  out  32  correct next PC; meaningful only while redirect=1.
- mem_req_valid  out  1  load request to the memory controller.
- mem_req_ready  in  1  memory controller accepts the request.
- mem_req_addr  out  32  load address.
- mem_rsp_valid  in  1  load data is valid.
- mem_rsp_data  in  32  load data.

## Operation
- Stage register holds: v, pc, type, cmp, alu, link, pred, rd. It captures the ex_* inputs when ex_stall=0. It captures v=0 when ex_valid=0.
- kill = (squash counter > 0). A captured valid instruction with kill=1 retires with no effect: no write, no branch resolution, no memory request. Each such instruction decrements the counter by 1.
- ALU: rf_we=1, rf_wdata=alu, for the one cycle the instruction is in the stage.
- BRANCH:
  - taken = link | cmp.
  - actual = taken ? alu : pc+4 (32-bit add, wraps).
  - link=1 writes rd <= pc+4.
  - If actual != pred, redirect=1 and redirect_pc=actual, and the squash counter loads FLUSH_DEPTH at the next edge.
  - Instructions already in Decode/Execute are the wrong path and are squashed by the counter.
- rf_we is always forced to 0 when rd==0; redirect is unaffected by rd.
- FSM, states RUN, MEM_REQ, MEM_WAIT:
  - RUN → MEM_REQ when a non-killed LOAD is captured.
  - MEM_REQ: mem_req_valid=1, mem_req_addr=alu. Address stays stable until accepted. Moves to MEM_WAIT on mem_req_ready=1.
  - MEM_WAIT, on mem_rsp_valid=1: rf_we=1 and rf_wdata=mem_rsp_data that cycle, then capture the next instruction. Next state is MEM_REQ if that instruction is a non-killed load, else RUN.
- ex_stall = (state==MEM_REQ) | (state==MEM_WAIT & ~mem_rsp_valid).
- mem_rsp_valid outside MEM_WAIT is ignored.

## Timing
- Reset (rst=0 at an edge):
  - v=0, state=RUN, squash counter=0.
  - Outputs ex_stall, rf_we, redirect and mem_req_valid are 0; all other outputs read 0.
  - Reset mid-load abandons the request; a late mem_rsp_valid is ignored.
- ALU/branch latency:
  - Inputs captured at edge N.
  - rf_we and redirect are combinational during cycle N..N+1.
  - Register write commits at edge N+1.
- Load latency: 1 cycle for capture, ≥1 cycle in MEM_REQ, then the response cycle. Minimum 3 cycles from capture to commit; the response arrives no earlier than 1 cycle after acceptance.
- Redirect and the squash counter load in the same cycle. Fetch's first correct-path instruction reaches this stage after the FLUSH_DEPTH squashed slots.
- Bubbles (ex_valid=0) do not decrement the counter.
- A load in the wrong path never issues mem_req_valid.

## Configuration
- WB_PERF_CNT_EN defined: adds outputs retire_count[31:0] and mispredict_count[31:0].
  - Both reset to 0 and wrap at 2^32.
  - retire_count increments once per non-killed valid instruction, on its commit edge.
  - mispredict_count increments on each redirect.
- WB_PERF_CNT_EN undefined: neither port nor counter exists.

## Test plan
- ALU, rd=5, alu=0x1234 → rf_we=1, waddr=5, wdata=0x1234 for exactly one cycle. Same with rd=0 → rf_we=0.
- BRANCH, pc=0x100, cmp=0, pred=0x104 → redirect=0. With cmp=1, alu=0x200 → redirect=1, redirect_pc=0x200; with FLUSH_DEPTH=2 the next two valid ALU writes are suppressed and the third writes.
- JAL, pc=0x40, alu=0x80, pred=0x80, rd=1 → rf writes x1=0x44, redirect=0.
- LOAD, alu=0x1000, mem_req_ready low for 3 cycles:
  - mem_req_valid high with addr 0x1000 and ex_stall high throughout.
  - Response 2 cycles after accept with data 0xDEADBEEF → x(rd)=0xDEADBEEF, ex_stall drops that cycle.
- Back-to-back loads → second request issues the cycle after the first response; no instruction is lost or duplicated.
- rst=0 during MEM_WAIT, then mem_rsp_valid=1 → no rf write; state RUN; all outputs 0.
